// File: rtl/ddr_arb_pkg.sv
// Shared types and widths for the two-requester DDR arbiter.
package ddr_arb_pkg;

    localparam int DDR_INDEX_W = 19;
    localparam int LINE_W      = 512;
    localparam int WORD_W      = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

endpackage

// File: rtl/ddr_arb_rr_picker.sv
// Combinational 2-way round-robin grant: on a tie the requester not served last wins.
module ddr_arb_rr_picker
    import ddr_arb_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic rr_last,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = ifu_valid | lsu_valid;
        grant_id    = REQ_IFU;
        if (ifu_valid && lsu_valid) begin
            grant_id = (rr_last == REQ_LSU) ? REQ_IFU : REQ_LSU;
        end else if (lsu_valid) begin
            grant_id = REQ_LSU;
        end
    end

endmodule

// File: rtl/ddr_arbiter.sv
// Sequences IFU burst reads and LSU single loads/stores onto one DDR port, one at a time.
// Optional WAIT-state watchdog enabled by defining DDR_ARB_TIMEOUT_EN.
module ddr_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int INDEX_W        = DDR_INDEX_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ifu_req_valid,
    input  logic [INDEX_W-1:0]  ifu_req_index,
    output logic                ifu_resp_valid,
    output logic [LINE_W-1:0]   ifu_resp_data,
    input  logic                lsu_req_valid,
    input  logic                lsu_req_write,
    input  logic [INDEX_W-1:0]  lsu_req_index,
    input  logic [WORD_W-1:0]   lsu_req_wdata,
    input  logic [WORD_W-1:0]   lsu_req_wmask,
    output logic                lsu_resp_valid,
    output logic [WORD_W-1:0]   lsu_resp_rdata,
    output logic                ddr_chip_enable,
    output logic [INDEX_W-1:0]  ddr_index,
    output logic                ddr_write_enable,
    output logic                ddr_burst_mode,
    output logic [WORD_W-1:0]   ddr_opstore_write_mask,
    output logic [WORD_W-1:0]   ddr_opstore_write_data,
    output logic [LINE_W-1:0]   ddr_l2_write_data,
    input  logic [WORD_W-1:0]   ddr_opload_read_data,
    input  logic [LINE_W-1:0]   ddr_pc_read_inst,
    input  logic                ddr_operation_done,
    output logic                arb_busy,
    output logic                arb_timeout
);

    state_t  state;
    req_id_t cur_id;
    req_id_t rr_last;
    logic    grant_valid;
    logic    grant_id;
    logic    timeout_hit;

    ddr_arb_rr_picker u_picker (
        .ifu_valid   (ifu_req_valid),
        .lsu_valid   (lsu_req_valid),
        .rr_last     (rr_last),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign ddr_l2_write_data = '0;
    assign arb_busy          = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= IDLE;
            cur_id                 <= REQ_IFU;
            rr_last                <= REQ_LSU;
            ifu_resp_valid         <= 1'b0;
            ifu_resp_data          <= '0;
            lsu_resp_valid         <= 1'b0;
            lsu_resp_rdata         <= '0;
            ddr_chip_enable        <= 1'b0;
            ddr_index              <= '0;
            ddr_write_enable       <= 1'b0;
            ddr_burst_mode         <= 1'b0;
            ddr_opstore_write_mask <= '0;
            ddr_opstore_write_data <= '0;
        end else begin
            ifu_resp_valid  <= 1'b0;
            lsu_resp_valid  <= 1'b0;
            ddr_chip_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cur_id          <= req_id_t'(grant_id);
                        ddr_chip_enable <= 1'b1;
                        state           <= ISSUE;
                        if (grant_id == REQ_IFU) begin
                            ddr_index              <= ifu_req_index;
                            ddr_write_enable       <= 1'b0;
                            ddr_burst_mode         <= 1'b1;
                            ddr_opstore_write_mask <= '0;
                            ddr_opstore_write_data <= '0;
                        end else begin
                            ddr_index              <= lsu_req_index;
                            ddr_write_enable       <= lsu_req_write;
                            ddr_burst_mode         <= 1'b0;
                            ddr_opstore_write_mask <= lsu_req_wmask;
                            ddr_opstore_write_data <= lsu_req_wdata;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    // Response pulse is raised on the transition so it lines up with the RESP cycle.
                    if (ddr_operation_done) begin
                        state <= RESP;
                        if (cur_id == REQ_IFU) begin
                            ifu_resp_valid <= 1'b1;
                            ifu_resp_data  <= ddr_pc_read_inst;
                        end else begin
                            lsu_resp_valid <= 1'b1;
                            if (!ddr_write_enable) begin
                                lsu_resp_rdata <= ddr_opload_read_data;
                            end
                        end
                    end else if (timeout_hit) begin
                        state <= RESP;
                        if (cur_id == REQ_IFU) begin
                            ifu_resp_valid <= 1'b1;
                        end else begin
                            lsu_resp_valid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    rr_last <= cur_id;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DDR_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a done in that same cycle still wins.
    assign timeout_hit = (state == WAIT) && !ddr_operation_done &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            arb_timeout <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout_hit) begin
                arb_timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_hit        = 1'b0;
    assign arb_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter with a behavioural DDR stub and per-requester scoreboards.
module tb_ddr_arbiter;
    import ddr_arb_pkg::*;

    localparam int IW = 19;
`ifdef DDR_ARB_TIMEOUT_EN
    localparam int TMO = 10;
`else
    localparam int TMO = 255;
`endif
    localparam int SINGLE_LAT = 6;
    localparam int BURST_LAT  = 10;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           ifu_req_valid = 1'b0;
    logic [IW-1:0]  ifu_req_index = '0;
    logic           ifu_resp_valid;
    logic [511:0]   ifu_resp_data;
    logic           lsu_req_valid = 1'b0;
    logic           lsu_req_write = 1'b0;
    logic [IW-1:0]  lsu_req_index = '0;
    logic [63:0]    lsu_req_wdata = '0;
    logic [63:0]    lsu_req_wmask = '0;
    logic           lsu_resp_valid;
    logic [63:0]    lsu_resp_rdata;
    logic           ddr_chip_enable;
    logic [IW-1:0]  ddr_index;
    logic           ddr_write_enable;
    logic           ddr_burst_mode;
    logic [63:0]    ddr_opstore_write_mask;
    logic [63:0]    ddr_opstore_write_data;
    logic [511:0]   ddr_l2_write_data;
    logic [63:0]    ddr_opload_read_data = '0;
    logic [511:0]   ddr_pc_read_inst = '0;
    logic           ddr_operation_done;
    logic           arb_busy;
    logic           arb_timeout;

    logic stub_done = 1'b0;
    logic spurious_done = 1'b0;
    assign ddr_operation_done = stub_done | spurious_done;

    ddr_arbiter #(.INDEX_W(IW), .TIMEOUT_CYCLES(TMO)) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .ifu_req_valid          (ifu_req_valid),
        .ifu_req_index          (ifu_req_index),
        .ifu_resp_valid         (ifu_resp_valid),
        .ifu_resp_data          (ifu_resp_data),
        .lsu_req_valid          (lsu_req_valid),
        .lsu_req_write          (lsu_req_write),
        .lsu_req_index          (lsu_req_index),
        .lsu_req_wdata          (lsu_req_wdata),
        .lsu_req_wmask          (lsu_req_wmask),
        .lsu_resp_valid         (lsu_resp_valid),
        .lsu_resp_rdata         (lsu_resp_rdata),
        .ddr_chip_enable        (ddr_chip_enable),
        .ddr_index              (ddr_index),
        .ddr_write_enable       (ddr_write_enable),
        .ddr_burst_mode         (ddr_burst_mode),
        .ddr_opstore_write_mask (ddr_opstore_write_mask),
        .ddr_opstore_write_data (ddr_opstore_write_data),
        .ddr_l2_write_data      (ddr_l2_write_data),
        .ddr_opload_read_data   (ddr_opload_read_data),
        .ddr_pc_read_inst       (ddr_pc_read_inst),
        .ddr_operation_done     (ddr_operation_done),
        .arb_busy               (arb_busy),
        .arb_timeout            (arb_timeout)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input int unsigned idx);
        return 64'hA5A5_0000_0000_0000 | 64'(idx) | (64'(idx) << 24);
    endfunction

    // DDR stub contents and the bench's independent reference copy.
    logic [63:0] ddr_mem   [int unsigned];
    logic [63:0] model_mem [int unsigned];

    function automatic logic [63:0] ddr_rd(input int unsigned idx);
        return ddr_mem.exists(idx) ? ddr_mem[idx] : init_word(idx);
    endfunction

    function automatic logic [63:0] model_rd(input int unsigned idx);
        return model_mem.exists(idx) ? model_mem[idx] : init_word(idx);
    endfunction

    logic          stub_busy = 1'b0;
    logic          stub_hang = 1'b0;
    int            stub_cnt = 0;
    int            n_strobes = 0;
    logic [IW-1:0] stub_idx = '0;
    logic          stub_burst = 1'b0;
    logic          stub_write = 1'b0;
    logic [63:0]   stub_wdata = '0;
    logic          grant_log [$];

    always @(negedge clock) begin
        if (!reset_n) begin
            stub_busy = 1'b0;
            stub_done = 1'b0;
        end else begin
            stub_done = 1'b0;
            if (ddr_chip_enable) begin
                n_strobes++;
                check("single_strobe_per_txn", stub_busy, 0);
                stub_busy  = 1'b1;
                stub_idx   = ddr_index;
                stub_burst = ddr_burst_mode;
                stub_write = ddr_write_enable;
                stub_wdata = ddr_opstore_write_data;
                stub_cnt   = ddr_burst_mode ? BURST_LAT : SINGLE_LAT;
                grant_log.push_back(ddr_burst_mode);
            end else if (stub_busy && !stub_hang) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    check("cmd_index_stable", ddr_index, stub_idx);
                    check("cmd_wdata_stable", ddr_opstore_write_data, stub_wdata);
                    if (ddr_burst_mode) begin
                        for (int i = 0; i < 8; i++)
                            ddr_pc_read_inst[i*64 +: 64] = ddr_rd(32'(stub_idx) + 32'(i));
                    end else if (ddr_write_enable) begin
                        ddr_mem[32'(stub_idx)] = (ddr_rd(32'(stub_idx)) & ~ddr_opstore_write_mask)
                                               | (ddr_opstore_write_data & ddr_opstore_write_mask);
                    end else begin
                        ddr_opload_read_data = ddr_rd(32'(stub_idx));
                    end
                    stub_done = 1'b1;
                    stub_busy = 1'b0;
                end
            end
        end
    end

    logic [511:0] ifu_q [$];
    logic [63:0]  lsu_q [$];
    logic [63:0]  exp_lsu_rdata = '0;

    always @(negedge clock) begin
        if (reset_n) begin
            if (ifu_resp_valid) begin
                check("ifu_resp_expected", 512'(ifu_q.size() != 0), 1);
                if (ifu_q.size() != 0) check("ifu_resp_data", ifu_resp_data, ifu_q.pop_front());
            end
            if (lsu_resp_valid) begin
                check("lsu_resp_expected", 512'(lsu_q.size() != 0), 1);
                if (lsu_q.size() != 0) check("lsu_resp_rdata", lsu_resp_rdata, lsu_q.pop_front());
            end
        end
    end

    task automatic wait_resp(input bit is_ifu, input bit toggle);
        int n = 0;
        bit got = 0;
        bit armed = 0;
        while (!got && n < 400) begin
            @(negedge clock);
            got = is_ifu ? ifu_resp_valid : lsu_resp_valid;
            if (toggle && ddr_chip_enable) armed = 1;
            else if (armed && !got) lsu_req_wdata = ~lsu_req_wdata;
            n++;
        end
        check(is_ifu ? "ifu_resp_arrived" : "lsu_resp_arrived", got, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic ifu_read(input logic [IW-1:0] idx, input bit hold_after);
        logic [511:0] line;
        for (int i = 0; i < 8; i++) line[i*64 +: 64] = model_rd(32'(idx) + 32'(i));
        ifu_q.push_back(line);
        ifu_req_index = idx;
        ifu_req_valid = 1'b1;
        wait_resp(1'b1, 1'b0);
        if (!hold_after) ifu_req_valid = 1'b0;
    endtask

    task automatic lsu_op(input bit wr, input logic [IW-1:0] idx, input logic [63:0] wdata,
                          input logic [63:0] wmask, input bit hold_after, input bit toggle);
        if (wr) begin
            model_mem[32'(idx)] = (model_rd(32'(idx)) & ~wmask) | (wdata & wmask);
        end else begin
            exp_lsu_rdata = model_rd(32'(idx));
        end
        lsu_q.push_back(exp_lsu_rdata);
        lsu_req_write = wr;
        lsu_req_index = idx;
        lsu_req_wdata = wdata;
        lsu_req_wmask = wmask;
        lsu_req_valid = 1'b1;
        wait_resp(1'b0, toggle);
        if (!hold_after) lsu_req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int s0;
        bit seen;
        int n;

        repeat (3) @(negedge clock);
        check("rst_ifu_resp_valid", ifu_resp_valid, 0);
        check("rst_ifu_resp_data", ifu_resp_data, 0);
        check("rst_lsu_resp_valid", lsu_resp_valid, 0);
        check("rst_lsu_resp_rdata", lsu_resp_rdata, 0);
        check("rst_chip_enable", ddr_chip_enable, 0);
        check("rst_index", ddr_index, 0);
        check("rst_write_enable", ddr_write_enable, 0);
        check("rst_burst_mode", ddr_burst_mode, 0);
        check("rst_wmask", ddr_opstore_write_mask, 0);
        check("rst_wdata", ddr_opstore_write_data, 0);
        check("rst_l2_wdata", ddr_l2_write_data, 0);
        check("rst_busy", arb_busy, 0);
        check("rst_timeout", arb_timeout, 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Both requesters valid from reset, held continuously: IFU first, then alternate.
        grant_log.delete();
        fork
            begin
                for (int k = 0; k < 4; k++) ifu_read(IW'(32'h40 + 8 * k), k != 3);
            end
            begin
                for (int k = 0; k < 4; k++) lsu_op(1'b0, IW'(32'h10 + k), '0, '0, k != 3, 1'b0);
            end
        join
        check("rr_grant_count", grant_log.size(), 8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            check($sformatf("rr_grant_%0d_is_burst", k), grant_log[k], (k % 2) == 0);

        // IFU-only burst read.
        s0 = n_strobes;
        ifu_read(IW'(32'h100), 1'b0);
        check("ifu_strobe_count", n_strobes - s0, 1);
        check("ifu_cmd_index", stub_idx, 32'h100);
        check("ifu_cmd_burst", stub_burst, 1);
        check("ifu_cmd_write", stub_write, 0);

        // Store then load of the same word.
        lsu_op(1'b1, IW'(32'h20), 64'hDEAD_BEEF, '1, 1'b0, 1'b0);
        lsu_op(1'b0, IW'(32'h20), '0, '0, 1'b0, 1'b0);
        check("load_after_store", lsu_resp_rdata, 64'hDEAD_BEEF);

        // Done pulse while idle must be ignored.
        @(negedge clock);
        spurious_done = 1'b1;
        @(negedge clock);
        spurious_done = 1'b0;
        check("spurious_done_idle", arb_busy, 0);

        // 100 mixed LSU ops with write data toggled during WAIT.
        s0 = n_strobes;
        for (int t = 0; t < 100; t++)
            lsu_op(1'($urandom_range(0, 1)), IW'(32'h20 + $urandom_range(0, 31)),
                   {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1);
        check("toggle_strobe_count", n_strobes - s0, 100);

        // Reset asserted during WAIT of an IFU burst.
        ifu_req_index = IW'(32'h200);
        ifu_req_valid = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            seen = ddr_chip_enable;
        end
        check("rst_mid_strobe_seen", seen, 1);
        repeat (3) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", arb_busy, 0);
        check("rst_mid_ifu_resp_valid", ifu_resp_valid, 0);
        check("rst_mid_ifu_resp_data", ifu_resp_data, 0);
        check("rst_mid_lsu_resp_rdata", lsu_resp_rdata, 0);
        check("rst_mid_index", ddr_index, 0);
        check("rst_mid_burst", ddr_burst_mode, 0);
        ifu_req_valid = 1'b0;
        exp_lsu_rdata = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        ifu_read(IW'(32'h300), 1'b0);
        lsu_op(1'b0, IW'(32'h10), '0, '0, 1'b0, 1'b0);

`ifdef DDR_ARB_TIMEOUT_EN
        // DDR never completes: watchdog must release the LSU with unchanged data.
        stub_hang = 1'b1;
        lsu_q.push_back(exp_lsu_rdata);
        lsu_req_write = 1'b0;
        lsu_req_index = IW'(32'h25);
        lsu_req_valid = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            seen = ddr_chip_enable;
        end
        check("tmo_strobe_seen", seen, 1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!arb_timeout && n < 50);
        check("tmo_cycles_to_flag", n, TMO + 1);
        check("tmo_resp_pulse", lsu_resp_valid, 1);
        @(posedge clock);
        #1;
        lsu_req_valid = 1'b0;
        @(negedge clock);
        check("tmo_back_to_idle", arb_busy, 0);
        check("tmo_sticky", arb_timeout, 1);
        check("tmo_no_second_pulse", lsu_resp_valid, 0);
`endif

        repeat (3) @(negedge clock);
        check("ifu_queue_drained", ifu_q.size(), 0);
        check("lsu_queue_drained", lsu_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
